// File: rtl/mmss_scan_display.sv
// mmss_scan_display: MM:SS four-digit multiplexed display driver.
// Frame-synchronous snapshot, BCD split, colon blink, flash, over-range dashes.
module mmss_scan_display #(
  parameter int SCAN_DIV  = 100000,
  parameter int BLINK_DIV = 500
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] min_bin,
  input  logic [7:0] sec_bin,
  input  logic       run,
  input  logic       flash,
  output logic [7:0] seg,
  output logic [3:0] an
);

  localparam int PW = $clog2(SCAN_DIV);
  localparam int BW = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;
  localparam logic [PW-1:0] PMAX = PW'(SCAN_DIV - 1);
  localparam logic [BW-1:0] BMAX = BW'(BLINK_DIV - 1);
  localparam logic [7:0] DASH = 8'h02;

  logic [PW-1:0] pcnt_q, pcnt_d;
  logic [BW-1:0] blink_q, blink_d;
  logic [1:0]    idx_q, idx_d;
  logic          phase_q, phase_d;
  logic [7:0]    min_s_q, min_s_d;
  logic [7:0]    sec_s_q, sec_s_d;
  logic          upd_q, upd_d;
  logic [3:0]    an_q, an_d;
  logic [7:0]    seg_q, seg_d;
  logic          tick;

  logic [3:0] min_t, min_o, sec_t, sec_o;
  logic       min_ovr, sec_ovr, colon;

  function automatic logic [7:0] enc(input logic [3:0] d);
    logic [7:0] p;
    unique case (d)
      4'd0:    p = 8'hFC;
      4'd1:    p = 8'h60;
      4'd2:    p = 8'hDA;
      4'd3:    p = 8'hF2;
      4'd4:    p = 8'h66;
      4'd5:    p = 8'hB6;
      4'd6:    p = 8'hBE;
      4'd7:    p = 8'hE0;
      4'd8:    p = 8'hFE;
      4'd9:    p = 8'hF6;
      default: p = 8'h00;
    endcase
    return p;
  endfunction

  // Scan prescaler, digit index, blink phase and frame snapshot.
  always_comb begin
    tick    = (pcnt_q == PMAX);
    pcnt_d  = tick ? '0 : pcnt_q + 1'b1;
    idx_d   = idx_q;
    phase_d = phase_q;
    blink_d = blink_q;
    min_s_d = min_s_q;
    sec_s_d = sec_s_q;
    upd_d   = tick;
    if (tick) begin
      idx_d = idx_q + 2'd1;
      if (idx_q == 2'd3) begin
        min_s_d = min_bin;
        sec_s_d = sec_bin;
      end
      if (blink_q == BMAX) begin
        blink_d = '0;
        phase_d = ~phase_q;
      end else begin
        blink_d = blink_q + 1'b1;
      end
    end
  end

  // Digit pattern for the slot that idx just moved to; held between refreshes.
  always_comb begin
    min_t   = 4'(min_s_q / 8'd10);
    min_o   = 4'(min_s_q % 8'd10);
    sec_t   = 4'(sec_s_q / 8'd10);
    sec_o   = 4'(sec_s_q % 8'd10);
    min_ovr = (min_s_q > 8'd99);
    sec_ovr = (sec_s_q > 8'd59);
    colon   = run ? phase_q : 1'b1;
    an_d    = an_q;
    seg_d   = seg_q;
    if (upd_q) begin
      unique case (idx_q)
        2'd0: begin
          an_d  = 4'b1110;
          seg_d = sec_ovr ? DASH : enc(sec_o);
        end
        2'd1: begin
          an_d  = 4'b1101;
          seg_d = sec_ovr ? DASH : enc(sec_t);
        end
        2'd2: begin
          an_d  = 4'b1011;
          seg_d = (min_ovr ? DASH : enc(min_o)) | {7'b0, colon};
        end
        2'd3: begin
          an_d  = 4'b0111;
          seg_d = min_ovr ? DASH :
                  (min_s_q < 8'd10) ? 8'h00 : enc(min_t);
        end
      endcase
      if (flash && !phase_q) an_d = 4'b1111;
    end
  end

  // State and output registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      pcnt_q  <= '0;
      blink_q <= '0;
      idx_q   <= 2'd3;
      phase_q <= 1'b1;
      min_s_q <= 8'd0;
      sec_s_q <= 8'd0;
      upd_q   <= 1'b0;
      an_q    <= 4'b1111;
      seg_q   <= 8'h00;
    end else begin
      pcnt_q  <= pcnt_d;
      blink_q <= blink_d;
      idx_q   <= idx_d;
      phase_q <= phase_d;
      min_s_q <= min_s_d;
      sec_s_q <= sec_s_d;
      upd_q   <= upd_d;
      an_q    <= an_d;
      seg_q   <= seg_d;
    end
  end

  assign seg = seg_q;
  assign an  = an_q;

endmodule
